// File: rtl/regfile_ctrl_pkg.sv
// Shared constants, enums and the destination-legality helper for the
// register-file write-back controller.
package regfile_ctrl_pkg;

  localparam int NUM_REGS         = 11;
  localparam int ADDR_W           = 4;
  localparam int DATA_W           = 32;
  localparam int PC_REG           = 9;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic {PRIO_MEM, PRIO_ALU} wb_prio_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_MEM, GNT_ALU} wb_gnt_e;

  // The PC+8 alias and anything past the last physical register never get written.
  function automatic logic legal_dest(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(NUM_REGS)) && (addr != ADDR_W'(PC_REG));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on commit, plus the RAW/WAW hazard compare for decode.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                hazard
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [NUM_REGS-1:0] w_rs1_hit;
  logic [NUM_REGS-1:0] w_rs2_hit;
  logic [NUM_REGS-1:0] w_waw_hit;
  logic                w_set_en;

  // Reservation is only taken when decode is not stalled this cycle.
  assign w_set_en = issue_valid && !hazard && legal_dest(issue_addr);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    localparam bit IS_PC = (gi == PC_REG);
    logic w_set;
    logic w_clr;

    assign w_set = w_set_en && (issue_addr == ADDR_W'(gi));
    assign w_clr = clr_en && (clr_addr == ADDR_W'(gi));
    // A same-cycle issue to a committing register keeps the newer reservation.
    assign w_busy_next[gi] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[gi]);

    assign w_rs1_hit[gi] = !IS_PC && r_busy[gi] && (rs1_addr == ADDR_W'(gi));
    assign w_rs2_hit[gi] = !IS_PC && r_busy[gi] && (rs2_addr == ADDR_W'(gi));
    assign w_waw_hit[gi] = issue_valid && r_busy[gi] && (issue_addr == ADDR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign hazard    = (|w_rs1_hit) || (|w_rs2_hit) || (|w_waw_hit);
  assign busy_mask = r_busy;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU and load results onto the single
// register-file write port with starvation-bounded priority.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                hazard,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                bad_addr
);

  localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

  wb_prio_e          r_state;
  wb_prio_e          w_state_next;
  wb_gnt_e           w_gnt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic              w_xfer;
  logic              w_alu_xfer;
  logic              w_legal;
  logic              w_commit;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_bad_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRIO_MEM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      PRIO_MEM: if (!w_alu_xfer && (w_cnt_next == LIMIT_C)) w_state_next = PRIO_ALU;
      PRIO_ALU: if (w_alu_xfer) w_state_next = PRIO_MEM;
    endcase
  end

  always_comb begin
    w_gnt = GNT_NONE;
    unique case (r_state)
      PRIO_MEM: begin
        if (mem_valid)      w_gnt = GNT_MEM;
        else if (alu_valid) w_gnt = GNT_ALU;
      end
      PRIO_ALU: begin
        if (alu_valid)      w_gnt = GNT_ALU;
        else if (mem_valid) w_gnt = GNT_MEM;
      end
    endcase
  end

  assign mem_ready  = (w_gnt == GNT_MEM);
  assign alu_ready  = (w_gnt == GNT_ALU);
  assign w_xfer     = (w_gnt != GNT_NONE);
  assign w_alu_xfer = (w_gnt == GNT_ALU);
  assign w_addr     = w_alu_xfer ? alu_addr : mem_addr;
  assign w_data     = w_alu_xfer ? alu_data : mem_data;
  assign w_legal    = legal_dest(w_addr);
  assign w_commit   = w_xfer && w_legal;

  // Counts stalled ALU cycles since the last ALU write, saturating at the limit.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_alu_xfer) begin
      w_cnt_next = 3'd0;
    end else if (alu_valid && (r_cnt < LIMIT_C)) begin
      w_cnt_next = r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_bad_addr <= 1'b0;
    end else begin
      r_wr_en <= w_commit;
      if (w_commit) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
      if (w_xfer && !w_legal) begin
        r_bad_addr <= 1'b1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign bad_addr = r_bad_addr;

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .clr_en      (w_commit),
    .clr_addr    (w_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .busy_mask   (busy_mask),
    .hazard      (hazard)
  );

endmodule
